// File: rtl/sigdel_decim.sv
// -----------------------------------------------------------------------------
// sigdel_decim
//
// Purpose:
//   Second-order CIC (sinc2) decimator for a 1-bit sigma-delta bitstream.
//   Every accepted input bit is integrated twice. On every R-th accepted bit
//   (R = 2**DEC_LOG2) the second integrator is passed through two comb
//   stages, and the result is scaled and saturated into an unsigned PCM
//   sample. The first two decimated results are discarded while the comb
//   delay line fills. Samples are produced from the third decimation
//   event onwards.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous, active-high reset (priority over everything)
//   ena        block enable; when low all state holds and out_valid is 0
//   in_bit     modulator output bit (weight 0 or 1)
//   in_valid   in_bit is accepted on an edge with ena=1 and in_valid=1
//   out_data   decimated sample, unsigned OUT_W bits, held between updates
//   out_valid  one-cycle pulse marking a new out_data value
//   settled    high once the first valid sample has been produced
// -----------------------------------------------------------------------------
module sigdel_decim #(
  parameter int DEC_LOG2 = 4,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             settled
);

  // Internal arithmetic width: y spans 0..R^2, which needs 2*DEC_LOG2+1 bits.
  // All integrator/comb math wraps modulo 2^BW; the comb differences recover
  // the true value because it always fits in BW bits.
  localparam int BW    = 2 * DEC_LOG2 + 1;
  localparam int SHIFT = 2 * DEC_LOG2 - OUT_W;

  localparam logic [DEC_LOG2-1:0] CNT_MAX = {DEC_LOG2{1'b1}};
  localparam logic [DEC_LOG2-1:0] CNT_ONE = {{(DEC_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    WARM0 = 2'd0,
    WARM1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Scale the comb output down to OUT_W bits and clamp. Only y = R^2 can
  // exceed the output range when SHIFT is zero, mapping full scale to all-ones.
  function automatic logic [OUT_W-1:0] map_sample(input logic [BW-1:0] y);
    logic [BW-1:0] scaled;
    scaled = y >> SHIFT;
    if (|scaled[BW-1:OUT_W]) begin
      map_sample = {OUT_W{1'b1}};
    end else begin
      map_sample = scaled[OUT_W-1:0];
    end
  endfunction

  // Registers
  logic [BW-1:0]       i1_q, i1_d;
  logic [BW-1:0]       i2_q, i2_d;
  logic [BW-1:0]       d1_q, d1_d;
  logic [BW-1:0]       d2_q, d2_d;
  logic [DEC_LOG2-1:0] cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                settled_q, settled_d;

  // Datapath signals
  logic                accept_s;
  logic                dec_event_s;
  logic [BW-1:0]       i1_sum_s;
  logic [BW-1:0]       i2_sum_s;
  logic [BW-1:0]       c1_s;
  logic [BW-1:0]       y_s;
  logic [OUT_W-1:0]    sample_s;

  // Integrator/comb arithmetic; the second integrator and the comb use the
  // already-updated values so a decimation event sees the R-th bit.
  always_comb begin
    accept_s    = ena & in_valid;
    dec_event_s = accept_s & (cnt_q == CNT_MAX);
    i1_sum_s    = i1_q + {{(BW-1){1'b0}}, in_bit};
    i2_sum_s    = i2_q + i1_sum_s;
    c1_s        = i2_sum_s - d1_q;
    y_s         = c1_s - d2_q;
    sample_s    = map_sample(y_s);
  end

  // Next-state logic for the filter state and the warm-up FSM.
  always_comb begin
    i1_d        = i1_q;
    i2_d        = i2_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    settled_d   = settled_q;

    if (accept_s) begin
      i1_d  = i1_sum_s;
      i2_d  = i2_sum_s;
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    // Comb delays advance on every decimation event, warm-up included, so the
    // delay line is primed by the time samples are released.
    if (dec_event_s) begin
      d1_d = i2_sum_s;
      d2_d = c1_s;
    end else begin
      d1_d = d1_q;
    end

    case (state_q)
      WARM0: begin
        if (dec_event_s) begin
          state_d = WARM1;
        end else begin
          state_d = WARM0;
        end
      end
      WARM1: begin
        if (dec_event_s) begin
          state_d = RUN;
        end else begin
          state_d = WARM1;
        end
      end
      RUN: begin
        if (dec_event_s) begin
          out_data_d  = sample_s;
          out_valid_d = 1'b1;
          settled_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WARM0;
      end
    endcase
  end

  // State register with synchronous reset; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q        <= '0;
      i2_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      cnt_q       <= '0;
      state_q     <= WARM0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      settled_q   <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      settled_q   <= settled_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign settled   = settled_q;

endmodule

// File: tb/tb_sigdel_decim.sv
// -----------------------------------------------------------------------------
// tb_sigdel_decim
//
// Directed bench for sigdel_decim with default parameters (R=16, OUT_W=8).
// A table of periodic bitstreams with hand-computed steady-state outputs is
// replayed back-to-back after a reset; hand-written sequences then cover
// gapped input with an enable drop, and a mid-frame reset.
// -----------------------------------------------------------------------------
module tb_sigdel_decim;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       in_bit;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       settled;

  sigdel_decim #(.DEC_LOG2(4), .OUT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .settled  (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         pat_len;  // pattern period in bits
    logic [3:0] pat;      // pat[0] is the first bit of each period
    int         nbits;    // accepted bits to send after reset
    logic [7:0] exp_val;  // hand-computed steady-state sample
  } vec_t;

  vec_t vecs[5];

  int checks;
  int errors;
  int acc;          // accepted bits since last reset (bench model)
  int pulses_seen;
  logic [7:0] exp_data;
  logic       exp_settled;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (acc=%0d, t=%0t)", name, act, exp, acc, $time);
    end
  endtask

  // Drive one cycle, then compare all outputs against the model.
  // A sample is expected after accepted bits 48, 64, 80, ... since reset.
  task automatic step(input logic b, input logic v, input logic e, input logic r,
                      input logic [7:0] steady_val);
    logic exp_valid;
    in_bit   = b;
    in_valid = v;
    ena      = e;
    rst      = r;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (r) begin
      acc         = 0;
      exp_data    = 8'd0;
      exp_settled = 1'b0;
    end else if (e && v) begin
      acc++;
      if (acc >= 48 && (acc % 16) == 0) begin
        exp_valid   = 1'b1;
        exp_data    = steady_val;
        exp_settled = 1'b1;
      end
    end
    chk("out_valid", int'(out_valid), int'(exp_valid));
    chk("out_data", int'(out_data), int'(exp_data));
    chk("settled", int'(settled), int'(exp_settled));
    if (out_valid) pulses_seen++;
  endtask

  function automatic logic pat_bit(input logic [3:0] pat, input int len, input int idx);
    logic [3:0] p;
    p = pat;
    return p[idx % len];
  endfunction

  initial begin
    int exp_pulses;
    int cyc;
    logic b;
    checks = 0;
    errors = 0;
    acc = 0;
    pulses_seen = 0;
    exp_data = 8'd0;
    exp_settled = 1'b0;
    rst = 1'b1;
    ena = 1'b0;
    in_bit = 1'b0;
    in_valid = 1'b0;

    vecs[0] = '{"zeros",       1, 4'b0000,   63, 8'd0};
    vecs[1] = '{"ones",        1, 4'b0001,  160, 8'd255};
    vecs[2] = '{"alt10",       2, 4'b0001,   96, 8'd128};
    vecs[3] = '{"p1000",       4, 4'b0001,   96, 8'd64};
    vecs[4] = '{"ones_wrap",   1, 4'b0001, 4096, 8'd255};

    // ---- table-driven gapless runs ----
    for (int v = 0; v < 5; v++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, vecs[v].exp_val);  // reset with a bit that must be dropped
      step(1'b0, 1'b0, 1'b1, 1'b0, vecs[v].exp_val);  // idle cycle, nothing accepted
      pulses_seen = 0;
      for (int k = 0; k < vecs[v].nbits; k++) begin
        step(pat_bit(vecs[v].pat, vecs[v].pat_len, k), 1'b1, 1'b1, 1'b0, vecs[v].exp_val);
      end
      exp_pulses = (vecs[v].nbits >= 48) ? ((vecs[v].nbits - 48) / 16 + 1) : 0;
      chk({vecs[v].name, "_pulses"}, pulses_seen, exp_pulses);
    end

    // ---- gapped 1,0 stream: random in_valid, ena dropped before bit 64 ----
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'd128);
    pulses_seen = 0;
    cyc = 0;
    while (acc < 96 && cyc < 2000) begin
      b = ((acc % 2) == 0);
      if (acc == 63) begin
        // 5 cycles with a valid bit offered but ena low: nothing accepted,
        // no pulse; the 64th-bit sample must still appear afterwards.
        for (int j = 0; j < 5; j++) begin
          step(b, 1'b1, 1'b0, 1'b0, 8'd128);
        end
        step(b, 1'b1, 1'b1, 1'b0, 8'd128);
      end else if ($urandom_range(0, 1) == 1) begin
        step(b, 1'b1, 1'b1, 1'b0, 8'd128);
      end else begin
        step(~b, 1'b0, 1'b1, 1'b0, 8'd128);   // ignored bit of opposite value
      end
      cyc++;
    end
    chk("gap_accepted", acc, 96);
    chk("gap_pulses", pulses_seen, 4);

    // ---- mid-frame reset: settle on 1,0, reset 8 bits into a frame ----
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'd128);
    for (int k = 0; k < 88; k++) begin
      step(((k % 2) == 0), 1'b1, 1'b1, 1'b0, 8'd128);
    end
    chk("pre_rst_data", int'(out_data), 128);
    chk("pre_rst_settled", int'(settled), 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'd128);           // step() checks all outputs cleared
    pulses_seen = 0;
    for (int k = 0; k < 48; k++) begin
      step(((k % 2) == 0), 1'b1, 1'b1, 1'b0, 8'd128);
    end
    chk("post_rst_pulses", pulses_seen, 1);
    chk("post_rst_data", int'(out_data), 128);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
